// File: rtl/rx_frame_decoder.sv
// Decodes classified Miller sequences (X/Y/Z/ERROR) into SOC/EOC strobes, data bytes and error strobes.
// Every output is registered one clk after its seq_valid; a new seq is accepted every cycle, no backpressure.
module rx_frame_decoder #(
    parameter int MAX_BYTES = 16,
    parameter int BC_W      = $clog2(MAX_BYTES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            seq_valid,
    input  logic [1:0]      seq,
    input  logic            parity_en,
    input  logic [2:0]      rx_align,
    output logic            soc,
    output logic            eoc,
    output logic [7:0]      data,
    output logic [2:0]      data_bits,
    output logic            data_valid,
    output logic            parity_error,
    output logic            sequence_error,
    output logic            overflow_error,
    output logic [BC_W-1:0] byte_count,
    output logic            last_bit
);
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_ERR_WAIT} state_t;

    localparam logic [1:0]      SEQ_X   = 2'd0;
    localparam logic [1:0]      SEQ_Y   = 2'd1;
    localparam logic [1:0]      SEQ_Z   = 2'd2;
    localparam logic [1:0]      SEQ_ERR = 2'd3;
    localparam logic [BC_W-1:0] BC_MAX  = BC_W'(MAX_BYTES);

    state_t          state_q, state_d;
    logic            prev_q, prev_d;
    logic [2:0]      bit_pos_q, bit_pos_d;
    logic            got_bit_q, got_bit_d;
    logic [7:0]      byte_q, byte_d;
    logic            par_en_q, par_en_d;
    logic [7:0]      data_q, data_d;
    logic [2:0]      dbits_q, dbits_d;
    logic [BC_W-1:0] bcnt_q, bcnt_d;
    logic            last_q, last_d;
    logic            soc_q, soc_d, eoc_q, eoc_d, dv_q, dv_d;
    logic            perr_q, perr_d, serr_q, serr_d, oerr_q, oerr_d;

    logic            is_eoc;
    logic            bit_val;
    logic [7:0]      byte_ins;

    // Y after a logic 0 ends the frame; otherwise X is 1 and Z / Y-after-1 are 0.
    assign is_eoc  = (seq == SEQ_Y) && !prev_q;
    assign bit_val = (seq == SEQ_X);

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        bit_pos_d = bit_pos_q;
        got_bit_d = got_bit_q;
        byte_d    = byte_q;
        par_en_d  = par_en_q;
        data_d    = data_q;
        dbits_d   = dbits_q;
        bcnt_d    = bcnt_q;
        last_d    = last_q;
        soc_d     = 1'b0;
        eoc_d     = 1'b0;
        dv_d      = 1'b0;
        perr_d    = 1'b0;
        serr_d    = 1'b0;
        oerr_d    = 1'b0;
        byte_ins  = byte_q;
        byte_ins[bit_pos_q] = bit_val;

        if (seq_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (seq == SEQ_Z) begin
                        soc_d     = 1'b1;
                        state_d   = ST_DATA;
                        prev_d    = 1'b0;
                        bit_pos_d = rx_align;
                        got_bit_d = 1'b0;
                        byte_d    = 8'h00;
                        bcnt_d    = '0;
                        par_en_d  = parity_en;
                    end
                end
                ST_DATA: begin
                    if (seq == SEQ_ERR) begin
                        serr_d  = 1'b1;
                        prev_d  = 1'b1;
                        state_d = ST_ERR_WAIT;
                    end else if (is_eoc) begin
                        eoc_d   = 1'b1;
                        state_d = ST_IDLE;
                        if (got_bit_q) begin
                            dv_d    = 1'b1;
                            data_d  = byte_q;
                            dbits_d = bit_pos_q;
                        end else if (bcnt_q == '0) begin
                            serr_d = 1'b1;
                        end
                    end else if (bcnt_q == BC_MAX) begin
                        oerr_d  = 1'b1;
                        prev_d  = bit_val;
                        state_d = ST_ERR_WAIT;
                    end else begin
                        prev_d    = bit_val;
                        last_d    = bit_val;
                        byte_d    = byte_ins;
                        got_bit_d = 1'b1;
                        bit_pos_d = bit_pos_q + 3'd1;
                        if (bit_pos_q == 3'd7) begin
                            if (par_en_q) begin
                                state_d = ST_PARITY;
                            end else begin
                                dv_d      = 1'b1;
                                data_d    = byte_ins;
                                dbits_d   = 3'd0;
                                bcnt_d    = bcnt_q + BC_W'(1);
                                byte_d    = 8'h00;
                                got_bit_d = 1'b0;
                            end
                        end
                    end
                end
                ST_PARITY: begin
                    if (seq == SEQ_ERR) begin
                        serr_d  = 1'b1;
                        prev_d  = 1'b1;
                        state_d = ST_ERR_WAIT;
                    end else if (is_eoc) begin
                        eoc_d   = 1'b1;
                        perr_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        prev_d = bit_val;
                        if (bit_val == ~^byte_q) begin
                            dv_d      = 1'b1;
                            data_d    = byte_q;
                            dbits_d   = 3'd0;
                            bcnt_d    = bcnt_q + BC_W'(1);
                            byte_d    = 8'h00;
                            got_bit_d = 1'b0;
                            bit_pos_d = 3'd0;
                            state_d   = ST_DATA;
                        end else begin
                            perr_d  = 1'b1;
                            state_d = ST_ERR_WAIT;
                        end
                    end
                end
                default: begin
                    // Only the logic level is tracked here so the real end of communication is found.
                    if (is_eoc) begin
                        eoc_d   = 1'b1;
                        dbits_d = 3'd0;
                        state_d = ST_IDLE;
                    end else begin
                        prev_d = (seq == SEQ_X) || (seq == SEQ_ERR);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            prev_q    <= 1'b0;
            bit_pos_q <= 3'd0;
            got_bit_q <= 1'b0;
            byte_q    <= 8'h00;
            par_en_q  <= 1'b0;
            data_q    <= 8'h00;
            dbits_q   <= 3'd0;
            bcnt_q    <= '0;
            last_q    <= 1'b0;
            soc_q     <= 1'b0;
            eoc_q     <= 1'b0;
            dv_q      <= 1'b0;
            perr_q    <= 1'b0;
            serr_q    <= 1'b0;
            oerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            bit_pos_q <= bit_pos_d;
            got_bit_q <= got_bit_d;
            byte_q    <= byte_d;
            par_en_q  <= par_en_d;
            data_q    <= data_d;
            dbits_q   <= dbits_d;
            bcnt_q    <= bcnt_d;
            last_q    <= last_d;
            soc_q     <= soc_d;
            eoc_q     <= eoc_d;
            dv_q      <= dv_d;
            perr_q    <= perr_d;
            serr_q    <= serr_d;
            oerr_q    <= oerr_d;
        end
    end

    assign soc            = soc_q;
    assign eoc            = eoc_q;
    assign data           = data_q;
    assign data_bits      = dbits_q;
    assign data_valid     = dv_q;
    assign parity_error   = perr_q;
    assign sequence_error = serr_q;
    assign overflow_error = oerr_q;
    assign byte_count     = bcnt_q;
    assign last_bit       = last_q;

endmodule

// File: tb/tb_rx_frame_decoder.sv
// Directed bench for rx_frame_decoder: table of whole frames plus hand-written corner sequences.
module tb_rx_frame_decoder;
    localparam logic [1:0] SX = 2'd0, SY = 2'd1, SZ = 2'd2, SE = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       seq_valid = 1'b0;
    logic [1:0] seq = 2'd0;
    logic       parity_en = 1'b0;
    logic [2:0] rx_align = 3'd0;

    logic a_soc, a_eoc, a_dv, a_perr, a_serr, a_oerr, a_last;
    logic [7:0] a_data;
    logic [2:0] a_db;
    logic [4:0] a_bc;
    logic b_soc, b_eoc, b_dv, b_perr, b_serr, b_oerr, b_last;
    logic [7:0] b_data;
    logic [2:0] b_db;
    logic [1:0] b_bc;

    always #5 clk = ~clk;

    rx_frame_decoder u_dut (
        .clk(clk), .rst(rst), .seq_valid(seq_valid), .seq(seq),
        .parity_en(parity_en), .rx_align(rx_align),
        .soc(a_soc), .eoc(a_eoc), .data(a_data), .data_bits(a_db), .data_valid(a_dv),
        .parity_error(a_perr), .sequence_error(a_serr), .overflow_error(a_oerr),
        .byte_count(a_bc), .last_bit(a_last)
    );

    rx_frame_decoder #(.MAX_BYTES(2)) u_dut2 (
        .clk(clk), .rst(rst), .seq_valid(seq_valid), .seq(seq),
        .parity_en(parity_en), .rx_align(rx_align),
        .soc(b_soc), .eoc(b_eoc), .data(b_data), .data_bits(b_db), .data_valid(b_dv),
        .parity_error(b_perr), .sequence_error(b_serr), .overflow_error(b_oerr),
        .byte_count(b_bc), .last_bit(b_last)
    );

    logic       use2 = 1'b0;
    logic       o_soc, o_eoc, o_dv, o_perr, o_serr, o_oerr, o_last;
    logic [7:0] o_data;
    logic [2:0] o_db;
    logic [4:0] o_bc;

    always_comb begin
        o_soc  = use2 ? b_soc  : a_soc;
        o_eoc  = use2 ? b_eoc  : a_eoc;
        o_dv   = use2 ? b_dv   : a_dv;
        o_perr = use2 ? b_perr : a_perr;
        o_serr = use2 ? b_serr : a_serr;
        o_oerr = use2 ? b_oerr : a_oerr;
        o_last = use2 ? b_last : a_last;
        o_data = use2 ? b_data : a_data;
        o_db   = use2 ? b_db   : a_db;
        o_bc   = use2 ? {3'b000, b_bc} : a_bc;
    end

    typedef struct {
        string       name;
        bit          par_en;
        logic [2:0]  align;
        bit          tog;
        bit          use2;
        int          nbytes;
        logic [23:0] bytes;
        int          last_n;
        logic [2:0]  flip;
        bit          no_par;
        int          e_dv;
        logic [7:0]  e_d0;
        logic [7:0]  e_d1;
        int          e_bc1;
        int          e_bc;
        logic [7:0]  e_data;
        int          e_db;
        int          e_perr;
        int          e_serr;
        int          e_oerr;
        int          e_dv_eoc;
        int          e_err_eoc;
        bit          e_last;
    } vec_t;

    vec_t vecs [8];

    int n_tests = 0;
    int n_fail  = 0;
    int soc_n, eoc_n, dv_n, perr_n, serr_n, oerr_n, dv_eoc_n, err_eoc_n, bc1;
    logic [7:0] dvd [4];
    logic enc_prev;
    logic tog_pend = 1'b0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic clear_mon();
        soc_n = 0; eoc_n = 0; dv_n = 0; perr_n = 0; serr_n = 0; oerr_n = 0;
        dv_eoc_n = 0; err_eoc_n = 0; bc1 = -1;
        for (int i = 0; i < 4; i++) dvd[i] = 8'h00;
    endtask

    task automatic sample();
        if (o_soc) soc_n++;
        if (o_eoc) begin
            eoc_n++;
            if (o_dv) dv_eoc_n++;
            if (o_perr || o_serr || o_oerr) err_eoc_n++;
        end
        if (o_dv) begin
            if (dv_n < 4) dvd[dv_n] = o_data;
            if (dv_n == 0) bc1 = int'(o_bc);
            dv_n++;
        end
        if (o_perr) perr_n++;
        if (o_serr) serr_n++;
        if (o_oerr) oerr_n++;
    endtask

    task automatic step(input logic [1:0] s);
        @(negedge clk);
        sample();
        if (tog_pend) begin
            parity_en = ~parity_en;
            rx_align  = ~rx_align;
            tog_pend  = 1'b0;
        end
        seq_valid = 1'b1;
        seq       = s;
    endtask

    task automatic idle();
        @(negedge clk);
        sample();
        seq_valid = 1'b0;
    endtask

    // Miller encoding of one logic bit: 1->X, 0 after 1->Y, 0 after 0->Z.
    task automatic send_bit(input logic b);
        if (b) step(SX);
        else if (enc_prev) step(SY);
        else step(SZ);
        enc_prev = b;
    endtask

    task automatic run_vec(input vec_t v);
        int lo, n;
        logic [7:0] b;
        clear_mon();
        use2      = v.use2;
        parity_en = v.par_en;
        rx_align  = v.align;
        step(SZ);
        enc_prev = 1'b0;
        tog_pend = v.tog;
        for (int bi = 0; bi < v.nbytes; bi++) begin
            b  = v.bytes[8*bi +: 8];
            lo = (bi == 0) ? int'(v.align) : 0;
            n  = (bi == v.nbytes - 1) ? v.last_n : 8 - lo;
            for (int k = lo; k < lo + n; k++) send_bit(b[k]);
            if (v.par_en && (lo + n == 8) && !(v.no_par && bi == v.nbytes - 1))
                send_bit((~^b) ^ v.flip[bi]);
        end
        if (enc_prev) step(SY);
        step(SY);
        idle();
        idle();
        check($sformatf("%s.soc", v.name), 32'(soc_n), 32'd1);
        check($sformatf("%s.eoc", v.name), 32'(eoc_n), 32'd1);
        check($sformatf("%s.dv_count", v.name), 32'(dv_n), 32'(v.e_dv));
        if (v.e_dv >= 1) check($sformatf("%s.byte0", v.name), 32'(dvd[0]), 32'(v.e_d0));
        if (v.e_dv >= 1) check($sformatf("%s.bc_first", v.name), 32'(bc1), 32'(v.e_bc1));
        if (v.e_dv >= 2) check($sformatf("%s.byte1", v.name), 32'(dvd[1]), 32'(v.e_d1));
        check($sformatf("%s.byte_count", v.name), 32'(o_bc), 32'(v.e_bc));
        check($sformatf("%s.data", v.name), 32'(o_data), 32'(v.e_data));
        check($sformatf("%s.data_bits", v.name), 32'(o_db), 32'(v.e_db));
        check($sformatf("%s.perr", v.name), 32'(perr_n), 32'(v.e_perr));
        check($sformatf("%s.serr", v.name), 32'(serr_n), 32'(v.e_serr));
        check($sformatf("%s.oerr", v.name), 32'(oerr_n), 32'(v.e_oerr));
        check($sformatf("%s.dv_at_eoc", v.name), 32'(dv_eoc_n), 32'(v.e_dv_eoc));
        check($sformatf("%s.err_at_eoc", v.name), 32'(err_eoc_n), 32'(v.e_err_eoc));
        check($sformatf("%s.last_bit", v.name), 32'(o_last), 32'(v.e_last));
    endtask

    initial begin
        //          name            par   align tog   use2  nb bytes       ln flip    nopar dv d0     d1     bc1 bc data   db perr serr oerr dveoc erreoc last
        vecs[0] = '{"a5_3d",        1'b1, 3'd0, 1'b1, 1'b0, 2, 24'h003DA5, 8, 3'b000, 1'b0, 2, 8'hA5, 8'h3D, 1, 2, 8'h3D, 0, 0, 0, 0, 0, 0, 1'b0};
        vecs[1] = '{"short_26",     1'b1, 3'd0, 1'b0, 1'b0, 1, 24'h000026, 7, 3'b000, 1'b0, 1, 8'h26, 8'h00, 0, 0, 8'h26, 7, 0, 0, 0, 1, 0, 1'b0};
        vecs[2] = '{"par_flip",     1'b1, 3'd0, 1'b0, 1'b0, 3, 24'h112093, 8, 3'b010, 1'b0, 1, 8'h93, 8'h00, 1, 1, 8'h93, 0, 1, 0, 0, 0, 0, 1'b0};
        vecs[3] = '{"overflow",     1'b0, 3'd0, 1'b0, 1'b1, 3, 24'hFFAA55, 8, 3'b000, 1'b0, 2, 8'h55, 8'hAA, 1, 2, 8'hAA, 0, 0, 0, 1, 0, 0, 1'b1};
        vecs[4] = '{"align3",       1'b1, 3'd3, 1'b0, 1'b0, 1, 24'h000068, 5, 3'b000, 1'b0, 1, 8'h68, 8'h00, 1, 1, 8'h68, 0, 0, 0, 0, 0, 0, 1'b0};
        vecs[5] = '{"align3_part",  1'b1, 3'd3, 1'b0, 1'b0, 1, 24'h000068, 2, 3'b000, 1'b0, 1, 8'h08, 8'h00, 0, 0, 8'h08, 5, 0, 0, 0, 1, 0, 1'b0};
        vecs[6] = '{"nopar_part",   1'b0, 3'd0, 1'b0, 1'b0, 2, 24'h0001C3, 2, 3'b000, 1'b0, 2, 8'hC3, 8'h01, 1, 1, 8'h01, 2, 0, 0, 0, 1, 0, 1'b0};
        vecs[7] = '{"par_missing",  1'b1, 3'd0, 1'b0, 1'b0, 1, 24'h000025, 8, 3'b000, 1'b1, 0, 8'h00, 8'h00, 0, 0, 8'h01, 2, 1, 0, 0, 0, 1, 1'b0};

        clear_mon();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset.strobes", 32'({o_soc, o_eoc, o_dv, o_perr, o_serr, o_oerr}), 32'd0);
        check("reset.data", 32'(o_data), 32'd0);
        check("reset.data_bits", 32'(o_db), 32'd0);
        check("reset.byte_count", 32'(o_bc), 32'd0);
        check("reset.last_bit", 32'(o_last), 32'd0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);
        use2 = 1'b0;

        // Z,Y: zero-bit frame.
        clear_mon();
        step(SZ); step(SY); idle(); idle();
        check("zy.soc", 32'(soc_n), 32'd1);
        check("zy.eoc", 32'(eoc_n), 32'd1);
        check("zy.serr", 32'(serr_n), 32'd1);
        check("zy.serr_at_eoc", 32'(err_eoc_n), 32'd1);
        check("zy.dv", 32'(dv_n), 32'd0);

        // Z,Y,Y: trailing Y in IDLE must be ignored.
        clear_mon();
        step(SZ); step(SY); step(SY); idle(); idle();
        check("zyy.soc", 32'(soc_n), 32'd1);
        check("zyy.eoc", 32'(eoc_n), 32'd1);
        check("zyy.serr", 32'(serr_n), 32'd1);

        // ERROR mid-byte, then end of communication (ERROR counts as logic 1).
        clear_mon();
        step(SZ); step(SX); step(SZ); step(SE); step(SY); step(SY); idle(); idle();
        check("err_mid.serr", 32'(serr_n), 32'd1);
        check("err_mid.eoc", 32'(eoc_n), 32'd1);
        check("err_mid.err_at_eoc", 32'(err_eoc_n), 32'd0);
        check("err_mid.dv", 32'(dv_n), 32'd0);
        check("err_mid.data_bits", 32'(o_db), 32'd0);

        // Reset mid-frame after one full byte and one extra bit.
        clear_mon();
        parity_en = 1'b0;
        rx_align  = 3'd0;
        step(SZ);
        repeat (9) step(SX);
        idle();
        check("pre_rst.dv", 32'(dv_n), 32'd1);
        check("pre_rst.byte_count", 32'(o_bc), 32'd1);
        check("pre_rst.data", 32'(o_data), 32'hFF);
        check("pre_rst.last_bit", 32'(o_last), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst.strobes", 32'({o_soc, o_eoc, o_dv, o_perr, o_serr, o_oerr}), 32'd0);
        check("mid_rst.data", 32'(o_data), 32'd0);
        check("mid_rst.data_bits", 32'(o_db), 32'd0);
        check("mid_rst.byte_count", 32'(o_bc), 32'd0);
        check("mid_rst.last_bit", 32'(o_last), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
        step(SZ); step(SY); idle(); idle();
        check("post_rst.soc", 32'(soc_n), 32'd1);
        check("post_rst.eoc", 32'(eoc_n), 32'd1);
        check("post_rst.serr", 32'(serr_n), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
